// File: rtl/simple_uart.sv
// Bus-attached 8N1 UART transmitter: TX queue, baud divider, idle interrupt.
// Macro SIMPLE_UART_FIFO_EN: defined -> FifoDepth-entry FIFO, undefined -> single holding register.
module simple_uart #(
  parameter int unsigned FifoDepth = 8,
  parameter logic [15:0] ClkDiv    = 16'd434
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // Handshake: every req_i cycle is accepted; rvalid_o (with rdata_o/err_o) follows exactly one cycle later.
  logic [7:0]      offs;
  logic            bad_addr, wr_tx, push, pop, full, empty;
  logic [7:0]      head;
  logic [CntW-1:0] count;
  logic [31:0]     status, rd_val;
  logic [15:0]     baud_div_q, div_eff, bit_len_q, baud_cnt_q;
  logic            irq_en_q, ovf_q, rvalid_q, err_q, irq_q, bit_end;
  logic [31:0]     rdata_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  tx_state_e       state_q, state_d;
  logic            unused_bits;

  assign unused_bits = ^{addr_i[31:10], addr_i[1:0], be_i[3:2], wdata_i[31:16]};

  assign offs     = addr_i[9:2];
  assign bad_addr = (offs >= 8'd4);
  assign wr_tx    = req_i & we_i & (offs == 8'd0);
  assign push     = wr_tx & be_i[0] & ~full;

`ifdef SIMPLE_UART_FIFO_EN
  localparam int unsigned PtrW = $clog2(FifoDepth);
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  assign full  = (cnt_q == CntW'(FifoDepth));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign full  = hold_vld_q;
  assign empty = ~hold_vld_q;
  assign head  = hold_q;
  assign count = CntW'(hold_vld_q);

  always_ff @(posedge clk_i) begin
    if (push) hold_q <= wdata_i[7:0];
  end

  // push requires an empty slot and pop a full one, so they never coincide here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   hold_vld_q <= 1'b0;
    else if (push) hold_vld_q <= 1'b1;
    else if (pop)  hold_vld_q <= 1'b0;
  end
`endif

  assign status = {17'b0, 7'(count), 4'b0, ovf_q, (state_q != IDLE), empty, full};

  always_comb begin
    rd_val = '0;
    case (offs[1:0])
      2'd1:    rd_val = status;
      2'd2:    rd_val = {16'b0, baud_div_q};
      2'd3:    rd_val = {31'b0, irq_en_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= (req_i && !we_i && !bad_addr) ? rd_val : '0;
      err_q    <= req_i & (bad_addr | (wr_tx & full));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      baud_div_q <= ClkDiv;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (req_i && we_i && offs == 8'd2) begin
        if (be_i[0]) baud_div_q[7:0]  <= wdata_i[7:0];
        if (be_i[1]) baud_div_q[15:8] <= wdata_i[15:8];
      end
      if (req_i && we_i && offs == 8'd3 && be_i[0]) irq_en_q <= wdata_i[0];
      if (wr_tx && full && be_i[0]) ovf_q <= 1'b1;
      else if (req_i && we_i && offs == 8'd1 && wdata_i[3]) ovf_q <= 1'b0;
    end
  end

  assign div_eff = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
  assign bit_end = (baud_cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:  if (!empty) begin state_d = START; pop = 1'b1; end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (!empty) begin state_d = START; pop = 1'b1; end
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The bit length is captured on every frame start so divider writes only affect later frames.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_len_q  <= 16'd1;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_en_q & empty & (state_q == IDLE);
      if (pop) begin
        shift_q    <= head;
        bit_idx_q  <= '0;
        bit_len_q  <= div_eff;
        baud_cnt_q <= div_eff - 16'd1;
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          baud_cnt_q <= bit_len_q - 16'd1;
          if (state_q == DATA) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_q <= baud_cnt_q - 16'd1;
        end
      end
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_simple_uart.sv
// Directed self-checking bench for simple_uart: register map, 8N1 frames, irq, reset abort, overflow.
module tb_simple_uart;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        tx_o;
  logic        irq_o;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd;
  logic        er;
  logic        seen;

  simple_uart dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .tx_o    (tx_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds req_i for one cycle and captures the response one cycle later.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    be_i    = be;
    @(negedge clk_i);
    req_i   = 1'b0;
    we_i    = 1'b0;
    be_i    = 4'h0;
    rd      = rdata_o;
    er      = err_o;
    check("rvalid", 32'(rvalid_o), 32'd1);
  endtask

  // Call right after the TXDATA write returns: the frame starts on the next sample.
  task automatic expect_frame(input string tag, input logic [7:0] data, input int len);
    logic e;
    int   b;
    for (int i = 0; i < 10 * len; i++) begin
      @(negedge clk_i);
      b = i / len;
      if (b == 0)      e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = data[b-1];
      check(tag, 32'(tx_o), 32'(e));
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Register map and error responses
    bus(1'b0, 32'h08, 32'h0, 4'hF);
    check("baud_rst", rd, 32'h0000_01B2);
    check("baud_rst_err", 32'(er), 32'd0);
    bus(1'b0, 32'h20, 32'h0, 4'hF);
    check("bad_rd_err", 32'(er), 32'd1);
    check("bad_rd_data", rd, 32'd0);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("status_rst", rd, 32'h2);
    bus(1'b1, 32'h08, 32'h0000_AB04, 4'b0001);
    bus(1'b0, 32'h08, 32'h0, 4'hF);
    check("baud_be_mask", rd, 32'h0000_0104);
    bus(1'b1, 32'h08, 32'h0000_0004, 4'b0011);
    bus(1'b1, 32'h10, 32'h0000_00FF, 4'hF);
    check("bad_wr_err", 32'(er), 32'd1);
    bus(1'b0, 32'h08, 32'h0, 4'hF);
    check("baud_4", rd, 32'h4);

    // 0x55 at 4 cycles per bit
    bus(1'b1, 32'h00, 32'h55, 4'h1);
    check("tx55_err", 32'(er), 32'd0);
    expect_frame("frame_55", 8'h55, 4);
    @(negedge clk_i);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("status_after_55", rd, 32'h2);

    // Idle interrupt around a 2-cycle-per-bit frame
    bus(1'b1, 32'h08, 32'h2, 4'h3);
    bus(1'b1, 32'h0C, 32'h1, 4'h1);
    bus(1'b1, 32'h00, 32'hC3, 4'h1);
    check("irq_before", 32'(irq_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk_i);
      seen = seen | irq_o;
    end
    check("irq_during", 32'(seen), 32'd0);
    @(negedge clk_i);
    check("irq_after", 32'(irq_o), 32'd1);
    bus(1'b1, 32'h0C, 32'h0, 4'h1);

    // Holding register occupancy, overflow, then reset mid-frame
    bus(1'b1, 32'h08, 32'h8, 4'h3);
    bus(1'b1, 32'h00, 32'hA1, 4'h1);
    check("wr_a_err", 32'(er), 32'd0);
    @(negedge clk_i);
    bus(1'b1, 32'h00, 32'hB2, 4'h1);
    check("wr_b_err", 32'(er), 32'd0);
    bus(1'b1, 32'h00, 32'hC3, 4'h1);
`ifdef SIMPLE_UART_FIFO_EN
    check("wr_c_err", 32'(er), 32'd0);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("status_busy", rd, 32'h204);
    bus(1'b1, 32'h04, 32'h8, 4'h1);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("status_clr", rd, 32'h204);
`else
    check("wr_c_err", 32'(er), 32'd1);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("status_busy", rd, 32'h10D);
    bus(1'b1, 32'h04, 32'h8, 4'h1);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("status_clr", rd, 32'h105);
`endif
    repeat (8) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("abort_tx", 32'(tx_o), 32'd1);
    check("abort_rvalid", 32'(rvalid_o), 32'd0);
    check("abort_irq", 32'(irq_o), 32'd0);
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("abort_status", rd, 32'h2);
    bus(1'b0, 32'h08, 32'h0, 4'hF);
    check("abort_baud", rd, 32'h1B2);
    seen = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      seen = seen & tx_o;
    end
    check("abort_line_idle", 32'(seen), 32'd1);

    // BAUDDIV=0 runs one cycle per bit
    bus(1'b1, 32'h08, 32'h0, 4'h3);
    bus(1'b1, 32'h00, 32'h01, 4'h1);
    expect_frame("frame_div0", 8'h01, 1);
    bus(1'b0, 32'h08, 32'h0, 4'hF);
    check("baud_0", rd, 32'h0);

`ifdef SIMPLE_UART_FIFO_EN
    // Ten back-to-back pushes into an 8-deep FIFO
    bus(1'b1, 32'h08, 32'd100, 4'h3);
    for (int k = 0; k < 10; k++) begin
      bus(1'b1, 32'h00, 32'(k), 4'h1);
      check("burst_err", 32'(er), (k == 9) ? 32'd1 : 32'd0);
    end
    bus(1'b0, 32'h04, 32'h0, 4'hF);
    check("burst_status", rd, 32'h80D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
